// File: rtl/neuron_potential_integrator_if.sv
// Handshake/bus bundle for neuron_potential_integrator.
// Defining NEURON_SATURATION_FLAG_EN adds the sat_flag signal to both modports.
interface neuron_potential_integrator_if #(
    parameter int POT_WIDTH    = 9,
    parameter int WEIGHT_WIDTH = 9
);
    logic                           start;
    logic signed [POT_WIDTH-1:0]    init_potential;
    logic signed [POT_WIDTH-1:0]    leak;
    logic signed [POT_WIDTH-1:0]    pos_threshold;
    logic signed [POT_WIDTH-1:0]    neg_threshold;
    logic signed [POT_WIDTH-1:0]    reset_potential;
    logic                           weight_valid;
    logic signed [WEIGHT_WIDTH-1:0] weight;
    logic                           weight_last;
    logic                           weight_ready;
    logic                           busy;
    logic signed [POT_WIDTH-1:0]    potential_out;
    logic                           spike_out;
    logic                           done;
`ifdef NEURON_SATURATION_FLAG_EN
    logic                           sat_flag;

    modport master (
        output start, init_potential, leak, pos_threshold, neg_threshold, reset_potential,
        output weight_valid, weight, weight_last,
        input  weight_ready, busy, potential_out, spike_out, done, sat_flag
    );
    modport slave (
        input  start, init_potential, leak, pos_threshold, neg_threshold, reset_potential,
        input  weight_valid, weight, weight_last,
        output weight_ready, busy, potential_out, spike_out, done, sat_flag
    );
`else
    modport master (
        output start, init_potential, leak, pos_threshold, neg_threshold, reset_potential,
        output weight_valid, weight, weight_last,
        input  weight_ready, busy, potential_out, spike_out, done
    );
    modport slave (
        input  start, init_potential, leak, pos_threshold, neg_threshold, reset_potential,
        input  weight_valid, weight, weight_last,
        output weight_ready, busy, potential_out, spike_out, done
    );
`endif
endinterface

// File: rtl/neuron_potential_integrator.sv
// Per-neuron integrate/leak/fire stage: accumulates saturating weights, leaks, thresholds, emits potential+spike.
// Optional sticky saturation flag (sat_flag) enabled by defining NEURON_SATURATION_FLAG_EN.
module neuron_potential_integrator #(
    parameter int POT_WIDTH    = 9,
    parameter int WEIGHT_WIDTH = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    neuron_potential_integrator_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        LEAK   = 3'd2,
        THRESH = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};

    // The sum carries one guard bit; disagreement between the top two bits means overflow.
    function automatic logic signed [POT_WIDTH-1:0] sat_clamp(input logic [POT_WIDTH:0] sum);
        logic signed [POT_WIDTH-1:0] res;
        if (sum[POT_WIDTH] != sum[POT_WIDTH-1]) begin
            if (sum[POT_WIDTH]) res = POT_MIN;
            else                res = POT_MAX;
        end else begin
            res = sum[POT_WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic sat_overflow(input logic [POT_WIDTH:0] sum);
        return sum[POT_WIDTH] ^ sum[POT_WIDTH-1];
    endfunction

    state_t                      state_r;
    logic signed [POT_WIDTH-1:0] acc_r;
    logic signed [POT_WIDTH-1:0] leak_r;
    logic signed [POT_WIDTH-1:0] pos_thr_r;
    logic signed [POT_WIDTH-1:0] neg_thr_r;
    logic signed [POT_WIDTH-1:0] rst_pot_r;
    logic signed [POT_WIDTH-1:0] potential_r;
    logic                        spike_r;
    logic                        done_r;
    logic                        busy_r;
    logic                        weight_ready_r;

    logic signed [POT_WIDTH-1:0] w_ext_s;
    logic signed [POT_WIDTH-1:0] add_b_s;
    logic        [POT_WIDTH:0]   add_sum_s;
    logic signed [POT_WIDTH-1:0] acc_next_s;
    logic                        hs_s;

    assign w_ext_s = POT_WIDTH'($signed(bus.weight));
    assign hs_s    = bus.weight_valid & weight_ready_r;

    // Shared saturating adder: leak operand in LEAK, incoming weight otherwise.
    always_comb begin
        add_b_s    = w_ext_s;
        add_sum_s  = '0;
        acc_next_s = '0;
        if (state_r == LEAK) begin
            add_b_s = leak_r;
        end else begin
            add_b_s = w_ext_s;
        end
        add_sum_s  = {acc_r[POT_WIDTH-1], acc_r} + {add_b_s[POT_WIDTH-1], add_b_s};
        acc_next_s = sat_clamp(add_sum_s);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            acc_r          <= '0;
            leak_r         <= '0;
            pos_thr_r      <= '0;
            neg_thr_r      <= '0;
            rst_pot_r      <= '0;
            potential_r    <= '0;
            spike_r        <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
            weight_ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        acc_r          <= bus.init_potential;
                        leak_r         <= bus.leak;
                        pos_thr_r      <= bus.pos_threshold;
                        neg_thr_r      <= bus.neg_threshold;
                        rst_pot_r      <= bus.reset_potential;
                        spike_r        <= 1'b0;
                        busy_r         <= 1'b1;
                        weight_ready_r <= 1'b1;
                        state_r        <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (hs_s) begin
                        acc_r <= acc_next_s;
                        if (bus.weight_last) begin
                            weight_ready_r <= 1'b0;
                            state_r        <= LEAK;
                        end
                    end
                end
                LEAK: begin
                    acc_r   <= acc_next_s;
                    state_r <= THRESH;
                end
                THRESH: begin
                    if (acc_r >= pos_thr_r) begin
                        spike_r     <= 1'b1;
                        potential_r <= rst_pot_r;
                    end else if (acc_r < neg_thr_r) begin
                        spike_r     <= 1'b0;
                        potential_r <= neg_thr_r;
                    end else begin
                        spike_r     <= 1'b0;
                        potential_r <= acc_r;
                    end
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r         <= 1'b0;
                    busy_r         <= 1'b0;
                    weight_ready_r <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

    assign bus.weight_ready  = weight_ready_r;
    assign bus.busy          = busy_r;
    assign bus.potential_out = potential_r;
    assign bus.spike_out     = spike_r;
    assign bus.done          = done_r;

`ifdef NEURON_SATURATION_FLAG_EN
    logic sat_r;

    // Sticky per-neuron clamp indicator over every accumulate and leak add.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_r <= 1'b0;
        end else if (state_r == IDLE && bus.start) begin
            sat_r <= 1'b0;
        end else if ((hs_s || state_r == LEAK) && sat_overflow(add_sum_s)) begin
            sat_r <= 1'b1;
        end
    end

    assign bus.sat_flag = sat_r;
`endif

endmodule

// File: tb/tb_neuron_potential_integrator.sv
// Table-driven scoreboard bench for neuron_potential_integrator (POT_WIDTH=9, WEIGHT_WIDTH=9).
module tb_neuron_potential_integrator;

    localparam int PW = 9;
    localparam int WW = 9;

    typedef struct {
        logic signed [PW-1:0] init;
        logic signed [PW-1:0] lk;
        logic signed [PW-1:0] pos;
        logic signed [PW-1:0] neg;
        logic signed [PW-1:0] rstp;
        int                   nw;
        logic signed [WW-1:0] w [4];
        int                   exp_pot;
        int                   exp_spike;
        int                   exp_sat;
    } vec_t;

    typedef struct {
        int pot;
        int spike;
        int sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_potential_integrator_if #(.POT_WIDTH(PW), .WEIGHT_WIDTH(WW)) bus ();

    neuron_potential_integrator #(.POT_WIDTH(PW), .WEIGHT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   cycle_cnt     = 0;
    int   done_count    = 0;
    int   n_cmp         = 0;
    int   n_err         = 0;
    int   last_hs_cycle = 0;
    exp_t exp_q[$];
    vec_t tbl[10];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_count <= done_count + 1;

    function automatic vec_t mk(int i0, int lk, int pt, int nt, int rp, int nw,
                                int w0, int w1, int w2, int w3, int ep, int es, int esat);
        vec_t v;
        v.init = PW'(i0); v.lk = PW'(lk); v.pos = PW'(pt); v.neg = PW'(nt); v.rstp = PW'(rp);
        v.nw = nw;
        v.w[0] = WW'(w0); v.w[1] = WW'(w1); v.w[2] = WW'(w2); v.w[3] = WW'(w3);
        v.exp_pot = ep; v.exp_spike = es; v.exp_sat = esat;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic start_neuron(input vec_t v);
        exp_t e;
        bus.init_potential  = v.init;
        bus.leak            = v.lk;
        bus.pos_threshold   = v.pos;
        bus.neg_threshold   = v.neg;
        bus.reset_potential = v.rstp;
        bus.start           = 1'b1;
        e.pot = v.exp_pot; e.spike = v.exp_spike; e.sat = v.exp_sat;
        exp_q.push_back(e);
        @(negedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        check("spike_cleared_on_start", int'(bus.spike_out), 0);
    endtask

    task automatic feed_weights(input vec_t v, input bit stall, input bit poke);
        for (int i = 0; i < v.nw; i++) begin
            if (stall) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk); #1;
                end
            end
            check("weight_ready_in_accum", int'(bus.weight_ready), 1);
            bus.weight       = v.w[i];
            bus.weight_valid = 1'b1;
            bus.weight_last  = (i == v.nw - 1);
            @(negedge clk); #1;
            bus.weight_valid = 1'b0;
            bus.weight_last  = 1'b0;
            bus.weight       = '0;
            if (i == v.nw - 1) last_hs_cycle = cycle_cnt;
            if (poke && i == 0 && v.nw > 1) begin
                bus.start          = 1'b1;
                bus.init_potential = 9'sd100;
                @(negedge clk); #1;
                bus.start          = 1'b0;
                bus.init_potential = v.init;
            end
        end
    endtask

    task automatic wait_done(input bit poke_in_done);
        bit   seen = 1'b0;
        exp_t e;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done within 40 cycles, expected a done pulse");
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
            e = exp_q.pop_front();
            check("potential_out", int'(bus.potential_out), e.pot);
            check("spike_out", int'(bus.spike_out), e.spike);
`ifdef NEURON_SATURATION_FLAG_EN
            check("sat_flag", int'(bus.sat_flag), e.sat);
`endif
            // Last weight accepted on edge N; done is visible after edge N+2.
            check("done_latency", cycle_cnt - last_hs_cycle, 2);
            check("busy_during_done", int'(bus.busy), 1);
            if (poke_in_done) bus.start = 1'b1;
            @(negedge clk); #1;
            bus.start = 1'b0;
            check("done_one_cycle", int'(bus.done), 0);
            check("busy_back_idle", int'(bus.busy), 0);
            check("weight_ready_idle", int'(bus.weight_ready), 0);
            check("potential_held", int'(bus.potential_out), e.pot);
        end
    endtask

    task automatic run(input vec_t v, input bit stall);
        start_neuron(v);
        feed_weights(v, stall, 1'b0);
        wait_done(1'b0);
    endtask

    initial begin
        int dc;
        tbl[0] = mk(  10, -1,  20,  -50,  0, 3,    5,    7, 3, 0,    0, 1, 0);
        tbl[1] = mk(   0,  0,  20,  -50,  0, 2,  -30,  -40, 0, 0,  -50, 0, 0);
        tbl[2] = mk( 250,  0, 255,  -50,  7, 2,  100,  100, 0, 0,    7, 1, 1);
        tbl[3] = mk(   5,  0,  20,  -50,  0, 1,    0,    0, 0, 0,    5, 0, 0);
        tbl[4] = mk(-250, -5,  20, -256,  0, 1, -100,    0, 0, 0, -256, 0, 1);
        tbl[5] = mk(   3,  2,  10,  -10,  0, 1,    4,    0, 0, 0,    9, 0, 0);
        tbl[6] = mk(   0,  0,  10,  -10, -3, 1,   10,    0, 0, 0,   -3, 1, 0);
        tbl[7] = mk( 255,  1, 100,  -10,  1, 1,    0,    0, 0, 0,    1, 1, 1);
        tbl[8] = mk( -50,  0,  20,  -50,  0, 1,    0,    0, 0, 0,  -50, 0, 0);
        tbl[9] = mk( 200,  0, 200,  -50,  0, 2,  100, -100, 0, 0,  155, 0, 1);

        rst = 1'b0;
        bus.start = 1'b0; bus.init_potential = '0; bus.leak = '0;
        bus.pos_threshold = '0; bus.neg_threshold = '0; bus.reset_potential = '0;
        bus.weight_valid = 1'b0; bus.weight = '0; bus.weight_last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_potential", int'(bus.potential_out), 0);
        check("rst_spike", int'(bus.spike_out), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_weight_ready", int'(bus.weight_ready), 0);
        rst = 1'b1;
        @(negedge clk); #1;

        // Every vector once back-to-back and once with random valid gaps.
        for (int i = 0; i < 10; i++) begin
            run(tbl[i], 1'b0);
            run(tbl[i], 1'b1);
        end

        // Start pulses during ACCUM and during DONE are both ignored.
        dc = done_count;
        start_neuron(tbl[0]);
        feed_weights(tbl[0], 1'b0, 1'b1);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("single_done_count", done_count - dc, 1);
        check("no_restart_busy", int'(bus.busy), 0);

        // Asynchronous abort while in LEAK, then a clean restart.
        start_neuron(tbl[1]);
        feed_weights(tbl[1], 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_potential", int'(bus.potential_out), 0);
        check("abort_spike", int'(bus.spike_out), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_weight_ready", int'(bus.weight_ready), 0);
        exp_q.delete();
        dc = done_count;
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_done", done_count - dc, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        run(tbl[3], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
